uart_apb_fifo_bridge: RTL and testbench
=======================================

// Module: uart_apb_fifo_bridge
// PURPOSE
//  APB3 slave between the RISC-V peripheral bus and a UART TX/RX core. Replaces the single-byte bridge.
//  Adds a TX FIFO and an RX FIFO, a TX launcher FSM, sticky error/overrun status, maskable interrupts and PSLVERR.
//  Sits on the APB decoder slot of the UART; its UART-side ports connect directly to the UART TX/RX engines.
// PARAMETERS
//  DATA_W    8  UART character width (5..9); sets the width of tx_data/rx_data and of the FIFO entries.
//  TX_DEPTH  8  TX FIFO entries; power of 2, 2..128.
//  RX_DEPTH  8  RX FIFO entries; power of 2, 2..128.
// PORTS
//  PCLK         in   1       APB clock; all logic is in this domain.
//  PRESETn      in   1       Asynchronous, active-low reset.
//  PSEL         in   1       APB select.
//  PENABLE      in   1       APB access phase.
//  PWRITE       in   1       1 = write.
//  PADDR        in   5       Byte address; only the offsets listed below are decoded.
//  PWDATA       in   32      Write data.
//  PRDATA       out  32      Read data; combinational and valid in the access phase.
//  PREADY       out  1       Always 1 (zero wait states).
//  PSLVERR      out  1       Error response; valid in the access phase only.
//  tx_data      out  DATA_W  Character to transmit; held stable from tx_start until tx_done.
//  tx_start     out  1       One-cycle pulse that launches a character.
//  tx_busy      in   1       UART TX engine is shifting.
//  tx_done      in   1       One-cycle pulse at the end of the stop bit.
//  rx_data      in   DATA_W  Received character.
//  rx_valid     in   1       One-cycle pulse when rx_data/rx_err are valid.
//  rx_err       in   3       {frame, parity, break}; sampled with rx_valid.
//  rx_enable    out  1       ENABLE[0].
//  tx_enable    out  1       ENABLE[1].
//  parity_type  out  2       CTRL[1:0].
//  baud_rate    out  2       CTRL[3:2].
//  irq          out  1       Registered, level: |(IRQ_STAT & IRQ_EN).
// BEHAVIOUR
//  Reset values: all registers 0, FIFOs empty, FSM in IDLE; every output is 0 except PREADY=1.
//  Access: a write/read is a cycle with PSEL & PENABLE (& PWRITE / & !PWRITE). Registers update on that PCLK edge.
//  Register map:
//   0x00 ENABLE    RW   [0] rx_en, [1] tx_en.
//   0x04 CTRL      RW   [1:0] parity, [3:2] baud; [4] tx_flush, [5] rx_flush: write-1, self-clearing, read as 0.
//   0x08 STATUS    RO   [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] overrun (sticky),
//                       [7:5] rx_err (sticky OR), [15:8] tx_count, [23:16] rx_count.
//                       Sticky bits are cleared by a STATUS read.
//   0x0C DATA      W: push TX FIFO.  R: pop RX FIFO, returns {0, head}.
//   0x10 IRQ_EN    RW   [0] rx_avail, [1] tx_empty, [2] error.
//   0x14 IRQ_STAT  W1C  Same bit positions as IRQ_EN; a set event in the same cycle wins over a clear.
//  PSLVERR=1, and the access has no effect, for any of these:
//   - unmapped address (read data 0);
//   - write to STATUS;
//   - DATA write with TX full or tx_en=0 (data dropped);
//   - DATA read with RX empty (returns 0).
//  TX FSM:
//   - IDLE->LOAD when tx_en & !tx_empty & !tx_busy.
//   - LOAD: tx_data<=head, pop, tx_start=1 for that cycle; ->WAIT.
//   - WAIT->IDLE on tx_done.
//   - Clearing tx_en in WAIT lets the current character finish.
//   - Latency from a DATA write into an empty FIFO (IDLE, !tx_busy) to tx_start: 2 cycles.
//  RX path:
//   - rx_valid & rx_en & !full: push rx_data.
//   - rx_valid & rx_en & full: drop the character, set overrun and IRQ_STAT[2].
//   - A nonzero rx_err ORs into STATUS[7:5] and sets IRQ_STAT[2]; the character is still pushed.
//   - rx_valid is ignored while rx_en=0.
//  Same-cycle push & pop: both occur and count is unchanged.
//   - Full + pop + push: no overrun / no PSLVERR.
//   - Empty + read: PSLVERR, and the push still lands.
//  Flush: empties the FIFO on that edge and takes priority over a same-cycle push; the FSM is not aborted.
//  IRQ_STAT set events:
//   - [0] on any RX push;
//   - [1] when a TX pop leaves the FIFO empty;
//   - [2] on overrun or on an rx_err event.
//  Pointers wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits wide and zero-extended into their 8-bit fields.
//  PRESETn asserted mid-character: everything returns to reset values immediately. tx_start never glitches.
// TESTING
//  Reset with tx_en=1: write DATA 0x41,0x42,0x43 -> tx_start pulses with tx_data 0x41,0x42,0x43, each after its tx_done;
//   IRQ_STAT[1]=1 after the third pop.
//  Fill TX (8 writes with tx_busy=1), then a 9th write -> PSLVERR=1, STATUS[15:8]=8, 9th byte never sent.
//  9 rx_valid pulses with RX_DEPTH=8 -> STATUS[4]=1, rx_count=8, irq=1 with IRQ_EN=4;
//   reads return the first 8 bytes in order, then a read on empty gives PSLVERR.
//  RX full, DATA read in the same cycle as rx_valid=0x5A -> no overrun; 0x5A is read last.
//  rx_err=3'b010 with rx_valid -> STATUS[6]=1 and the byte is stored; a STATUS read clears it.
//   A W1C of 0x4 to IRQ_STAT in the same cycle as a new error leaves bit 2 set.
//  PRESETn pulsed during WAIT with 3 bytes queued -> FIFOs empty, tx_start=0, all registers 0.

Source files
------------

// File: rtl/uart_apb_fifo_bridge.sv
// rtl/uart_apb_fifo_bridge.sv - APB3 slave bridging the peripheral bus to a UART TX/RX core through TX and RX FIFOs
//
// Ports:
//   PCLK, PRESETn                     clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request; PRDATA/PREADY/PSLVERR response (zero wait states)
//   tx_data/tx_start                  character launch towards the TX engine; tx_busy/tx_done back
//   rx_data/rx_valid/rx_err           received character from the RX engine
//   rx_enable/tx_enable               ENABLE register bits
//   parity_type/baud_rate             CTRL register fields
//   irq                               registered level interrupt
module uart_apb_fifo_bridge #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [4:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic [2:0]        rx_err,
    output logic              rx_enable,
    output logic              tx_enable,
    output logic [1:0]        parity_type,
    output logic [1:0]        baud_rate,
    output logic              irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_CW = RX_AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        enable_q, enable_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [2:0]        irq_en_q, irq_en_d;
    logic [2:0]        irq_stat_q, irq_stat_d;
    logic              overrun_q, overrun_d;
    logic [2:0]        rx_err_st_q, rx_err_st_d;
    logic              irq_q, irq_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [TX_AW-1:0]  tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_CW-1:0]  tx_count_q, tx_count_d;
    logic [RX_AW-1:0]  rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_CW-1:0]  rx_count_q, rx_count_d;
    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];

    logic wr_acc, rd_acc, mapped;
    logic sel_enable, sel_ctrl, sel_status, sel_data, sel_irq_en, sel_irq_stat;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic data_wr, data_rd, tx_flush, rx_flush, st_rd;
    logic tx_push, tx_pop, rx_ev, rx_push, rx_pop, rx_over;
    logic err_set, tx_empty_set;
    logic unused_pwdata;

    assign wr_acc       = PSEL & PENABLE & PWRITE;
    assign rd_acc       = PSEL & PENABLE & ~PWRITE;
    assign sel_enable   = (PADDR == 5'h00);
    assign sel_ctrl     = (PADDR == 5'h04);
    assign sel_status   = (PADDR == 5'h08);
    assign sel_data     = (PADDR == 5'h0C);
    assign sel_irq_en   = (PADDR == 5'h10);
    assign sel_irq_stat = (PADDR == 5'h14);
    assign mapped       = sel_enable | sel_ctrl | sel_status | sel_data | sel_irq_en | sel_irq_stat;
    assign unused_pwdata = ^PWDATA;

    assign tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count_q == '0);

    assign data_wr  = wr_acc & sel_data;
    assign data_rd  = rd_acc & sel_data;
    assign tx_flush = wr_acc & sel_ctrl & PWDATA[4];
    assign rx_flush = wr_acc & sel_ctrl & PWDATA[5];
    assign st_rd    = rd_acc & sel_status;

    // Flush wins over any same-edge push or pop on that FIFO.
    assign tx_push = data_wr & enable_q[1] & ~tx_full & ~tx_flush;
    assign tx_pop  = (state_q == ST_LOAD) & ~tx_empty & ~tx_flush;
    assign rx_ev   = rx_valid & enable_q[0];
    assign rx_pop  = data_rd & ~rx_empty & ~rx_flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign rx_push = rx_ev & (~rx_full | rx_pop) & ~rx_flush;
    assign rx_over = rx_ev & rx_full & ~rx_pop & ~rx_flush;

    assign err_set      = rx_over | (rx_ev & (|rx_err));
    assign tx_empty_set = tx_pop & ~tx_push & (tx_count_q == TX_CW'(1));

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & (~mapped | (PWRITE & sel_status) |
                     (data_wr & (tx_full | ~enable_q[1])) | (data_rd & rx_empty));

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                5'h00: PRDATA[1:0] = enable_q;
                5'h04: PRDATA[3:0] = ctrl_q;
                5'h08: PRDATA = {8'd0, 8'(rx_count_q), 8'(tx_count_q), rx_err_st_q, overrun_q,
                                 rx_empty, rx_full, tx_empty, tx_full};
                5'h0C: if (!rx_empty) PRDATA[DATA_W-1:0] = rx_mem_q[rx_rd_ptr_q];
                5'h10: PRDATA[2:0] = irq_en_q;
                5'h14: PRDATA[2:0] = irq_stat_q;
                default: PRDATA = '0;
            endcase
        end
    end

    always_comb begin
        enable_d    = enable_q;
        ctrl_d      = ctrl_q;
        irq_en_d    = irq_en_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        state_d     = state_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;

        if (wr_acc && sel_enable) enable_d = PWDATA[1:0];
        if (wr_acc && sel_ctrl)   ctrl_d   = PWDATA[3:0];
        if (wr_acc && sel_irq_en) irq_en_d = PWDATA[2:0];

        if (tx_flush) begin
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_count_d  = '0;
        end else begin
            if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
            if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
            tx_count_d = tx_count_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
        end

        if (rx_flush) begin
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_count_d  = '0;
        end else begin
            if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
            if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
            rx_count_d = rx_count_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
        end

        // Sticky bits: a set event on the clearing read survives it.
        overrun_d   = (overrun_q & ~st_rd) | rx_over;
        rx_err_st_d = (rx_err_st_q & {3{~st_rd}}) | (rx_ev ? rx_err : 3'b000);
        irq_stat_d  = (irq_stat_q & ~((wr_acc && sel_irq_stat) ? PWDATA[2:0] : 3'b000)) |
                      {err_set, tx_empty_set, rx_push};
        irq_d       = |(irq_stat_d & irq_en_d);

        // tx_data is captured on the IDLE->LOAD edge so it is stable while tx_start is high;
        // the FIFO pop follows on the LOAD->WAIT edge.
        case (state_q)
            ST_IDLE: begin
                if (enable_q[1] && !tx_empty && !tx_busy) begin
                    state_d    = ST_LOAD;
                    tx_start_d = 1'b1;
                    tx_data_d  = tx_mem_q[tx_rd_ptr_q];
                end
            end
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: if (tx_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            enable_q    <= '0;
            ctrl_q      <= '0;
            irq_en_q    <= '0;
            irq_stat_q  <= '0;
            overrun_q   <= 1'b0;
            rx_err_st_q <= '0;
            irq_q       <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            ctrl_q      <= ctrl_d;
            irq_en_q    <= irq_en_d;
            irq_stat_q  <= irq_stat_d;
            overrun_q   <= overrun_d;
            rx_err_st_q <= rx_err_st_d;
            irq_q       <= irq_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers and counts.
    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= PWDATA[DATA_W-1:0];
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data;
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign rx_enable   = enable_q[0];
    assign tx_enable   = enable_q[1];
    assign parity_type = ctrl_q[1:0];
    assign baud_rate   = ctrl_q[3:2];
    assign irq         = irq_q;
endmodule

// File: tb/tb_uart_apb_fifo_bridge.sv
// tb/tb_uart_apb_fifo_bridge.sv - directed self-checking bench for uart_apb_fifo_bridge
module tb_uart_apb_fifo_bridge;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [4:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0, tx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [2:0]  rx_err = '0;
    logic        rx_enable, tx_enable, irq;
    logic [1:0]  parity_type, baud_rate;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    uart_apb_fifo_bridge #(.DATA_W(8), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .rx_enable(rx_enable), .tx_enable(tx_enable), .parity_type(parity_type),
        .baud_rate(baud_rate), .irq(irq)
    );

    always #5 PCLK = ~PCLK;
    always @(negedge PCLK) if (tx_start) start_cnt++;

    task automatic do_reset();
        PRESETn = 1'b0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    task automatic apb_xfer(input logic wr, input logic [4:0] a, input logic [31:0] d,
                            input logic with_rx, input logic [7:0] rxd, input logic [2:0] rxe,
                            output logic [31:0] rdata, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (with_rx) begin
            rx_valid = 1'b1; rx_data = rxd; rx_err = rxe;
        end
        #3;
        rdata = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; rx_valid = 1'b0; rx_err = '0;
    endtask

    task automatic apb_wr(input logic [4:0] a, input logic [31:0] d, output logic err);
        logic [31:0] r;
        apb_xfer(1'b1, a, d, 1'b0, 8'h00, 3'b000, r, err);
    endtask

    task automatic apb_rd(input logic [4:0] a, output logic [31:0] r, output logic err);
        apb_xfer(1'b0, a, 32'h0, 1'b0, 8'h00, 3'b000, r, err);
    endtask

    task automatic rx_send(input logic [7:0] d, input logic [2:0] e);
        @(posedge PCLK); #1;
        rx_valid = 1'b1; rx_data = d; rx_err = e;
        @(posedge PCLK); #1;
        rx_valid = 1'b0; rx_err = '0;
    endtask

    task automatic pulse_done();
        @(posedge PCLK); #1 tx_done = 1'b1;
        @(posedge PCLK); #1 tx_done = 1'b0;
    endtask

    task automatic wait_start(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge PCLK); #1;
            if (tx_start) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic e;
        do_reset();
        #2;
        checks++;
        if ({PREADY, PSLVERR, PRDATA, tx_start, tx_data, rx_enable, tx_enable, parity_type, baud_rate, irq}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: PREADY=%b PSLVERR=%b PRDATA=%h tx_start=%b tx_data=%h en=%b%b ctrl=%b%b irq=%b",
                     PREADY, PSLVERR, PRDATA, tx_start, tx_data, tx_enable, rx_enable, baud_rate, parity_type, irq);
        end
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h0000000A || e !== 1'b0) begin
            errors++; $display("FAIL reset_status: got %h err=%b expected 0000000a err=0", r, e);
        end
    endtask

    task automatic test_pslverr();
        logic [31:0] r;
        logic e;
        do_reset();
        apb_wr(5'h0C, 32'h55, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL data_wr_tx_disabled: err=%b expected 1", e); end
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h0000000A) begin errors++; $display("FAIL dropped_byte_count: got %h expected 0000000a", r); end
        apb_rd(5'h18, r, e);
        checks++;
        if (r !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL unmapped_rd: got %h err=%b expected 0 err=1", r, e); end
        apb_rd(5'h02, r, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL misaligned_rd: err=%b expected 1", e); end
        apb_wr(5'h08, 32'hFFFF_FFFF, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL status_wr: err=%b expected 1", e); end
        apb_wr(5'h00, 32'h3, e);
        apb_rd(5'h00, r, e);
        checks++;
        if (r !== 32'h3 || e !== 1'b0 || rx_enable !== 1'b1 || tx_enable !== 1'b1) begin
            errors++; $display("FAIL enable_rw: got %h err=%b rx=%b tx=%b expected 3 err=0 1 1", r, e, rx_enable, tx_enable);
        end
    endtask

    task automatic test_tx_sequence();
        logic [31:0] r;
        logic e, seen;
        do_reset();
        apb_wr(5'h00, 32'h2, e);
        apb_wr(5'h0C, 32'h41, e);
        checks++;
        if (e !== 1'b0 || tx_start !== 1'b0) begin
            errors++; $display("FAIL tx_first_write: err=%b tx_start=%b expected 0 0", e, tx_start);
        end
        @(posedge PCLK); #1;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
            errors++; $display("FAIL tx_latency: tx_start=%b tx_data=%h expected 1 41", tx_start, tx_data);
        end
        @(posedge PCLK); #1;
        checks++;
        if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_start_width: tx_start=%b expected 0", tx_start); end
        apb_wr(5'h0C, 32'h42, e);
        apb_wr(5'h0C, 32'h43, e);
        apb_wr(5'h14, 32'h7, e);
        repeat (4) @(posedge PCLK);
        #1;
        checks++;
        if (start_cnt !== 1 || tx_data !== 8'h41) begin
            errors++; $display("FAIL tx_wait_hold: starts=%0d tx_data=%h expected 1 41", start_cnt, tx_data);
        end
        pulse_done();
        wait_start(seen);
        checks++;
        if (!seen || tx_data !== 8'h42) begin
            errors++; $display("FAIL tx_second: seen=%b tx_data=%h expected 1 42", seen, tx_data);
        end
        apb_rd(5'h14, r, e);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL tx_irq_not_empty: got %h expected 0", r); end
        pulse_done();
        wait_start(seen);
        checks++;
        if (!seen || tx_data !== 8'h43) begin
            errors++; $display("FAIL tx_third: seen=%b tx_data=%h expected 1 43", seen, tx_data);
        end
        apb_rd(5'h14, r, e);
        checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL tx_irq_empty: got %h expected 2", r); end
        pulse_done();
        repeat (5) @(posedge PCLK);
        #1;
        checks++;
        if (start_cnt !== 3) begin errors++; $display("FAIL tx_start_count: got %0d expected 3", start_cnt); end
    endtask

    task automatic test_tx_full();
        logic [31:0] r;
        logic e, seen;
        int base;
        int bad;
        do_reset();
        base = start_cnt;
        tx_busy = 1'b1;
        apb_wr(5'h00, 32'h2, e);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            apb_wr(5'h0C, 32'h10 + i, e);
            if (e !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL tx_fill_err: %0d errors expected 0", bad); end
        apb_wr(5'h0C, 32'h99, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL tx_full_wr: err=%b expected 1", e); end
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h00000809) begin errors++; $display("FAIL tx_full_status: got %h expected 00000809", r); end
        tx_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_start(seen);
            checks++;
            if (!seen || tx_data !== 8'(8'h10 + i)) begin
                errors++; $display("FAIL tx_drain_%0d: seen=%b tx_data=%h expected 1 %h", i, seen, tx_data, 8'(8'h10 + i));
            end
            pulse_done();
        end
        repeat (10) @(posedge PCLK);
        #1;
        checks++;
        if (start_cnt - base !== 8) begin errors++; $display("FAIL tx_ninth_sent: starts=%0d expected 8", start_cnt - base); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] r;
        logic e;
        int bad;
        do_reset();
        apb_wr(5'h00, 32'h1, e);
        apb_wr(5'h10, 32'h4, e);
        for (int i = 0; i < 8; i++) rx_send(8'(8'h30 + i), 3'b000);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rx_full_no_irq: irq=%b expected 0", irq); end
        rx_send(8'hEE, 3'b000);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rx_overrun_irq: irq=%b expected 1", irq); end
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h00080016) begin errors++; $display("FAIL rx_overrun_status: got %h expected 00080016", r); end
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h00080006) begin errors++; $display("FAIL rx_overrun_clear: got %h expected 00080006", r); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            apb_rd(5'h0C, r, e);
            if (r !== 32'(8'h30 + i) || e !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rx_order: %0d wrong reads expected 0", bad); end
        apb_rd(5'h0C, r, e);
        checks++;
        if (r !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL rx_empty_rd: got %h err=%b expected 0 err=1", r, e); end
    endtask

    task automatic test_rx_pop_push();
        logic [31:0] r;
        logic e;
        int bad;
        do_reset();
        apb_wr(5'h00, 32'h1, e);
        for (int i = 0; i < 8; i++) rx_send(8'(8'h60 + i), 3'b000);
        apb_xfer(1'b0, 5'h0C, 32'h0, 1'b1, 8'h5A, 3'b000, r, e);
        checks++;
        if (r !== 32'h60 || e !== 1'b0) begin errors++; $display("FAIL rx_full_pop_push: got %h err=%b expected 60 err=0", r, e); end
        apb_rd(5'h14, r, e);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL rx_pop_push_irq: got %h expected 1", r); end
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h00080006) begin errors++; $display("FAIL rx_pop_push_status: got %h expected 00080006", r); end
        bad = 0;
        for (int i = 1; i < 8; i++) begin
            apb_rd(5'h0C, r, e);
            if (r !== 32'(8'h60 + i)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rx_pop_push_order: %0d wrong reads expected 0", bad); end
        apb_rd(5'h0C, r, e);
        checks++;
        if (r !== 32'h5A) begin errors++; $display("FAIL rx_last_5a: got %h expected 5a", r); end
        apb_xfer(1'b0, 5'h0C, 32'h0, 1'b1, 8'h77, 3'b000, r, e);
        checks++;
        if (r !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL rx_empty_rd_push: got %h err=%b expected 0 err=1", r, e); end
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h00010002) begin errors++; $display("FAIL rx_empty_push_landed: got %h expected 00010002", r); end
        apb_rd(5'h0C, r, e);
        checks++;
        if (r !== 32'h77) begin errors++; $display("FAIL rx_read_77: got %h expected 77", r); end
    endtask

    task automatic test_rx_err();
        logic [31:0] r;
        logic e;
        do_reset();
        apb_wr(5'h00, 32'h1, e);
        rx_send(8'h11, 3'b010);
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h00010042) begin errors++; $display("FAIL rx_err_status: got %h expected 00010042", r); end
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h00010002) begin errors++; $display("FAIL rx_err_clear: got %h expected 00010002", r); end
        apb_rd(5'h14, r, e);
        checks++;
        if (r !== 32'h5) begin errors++; $display("FAIL rx_err_irq: got %h expected 5", r); end
        apb_xfer(1'b1, 5'h14, 32'h4, 1'b1, 8'h22, 3'b001, r, e);
        apb_rd(5'h14, r, e);
        checks++;
        if (r !== 32'h5) begin errors++; $display("FAIL w1c_vs_set: got %h expected 5", r); end
        apb_wr(5'h14, 32'h4, e);
        apb_rd(5'h14, r, e);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL w1c_clear: got %h expected 1", r); end
        apb_rd(5'h0C, r, e);
        checks++;
        if (r !== 32'h11 || e !== 1'b0) begin errors++; $display("FAIL rx_err_byte: got %h err=%b expected 11 err=0", r, e); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        logic e;
        do_reset();
        apb_wr(5'h00, 32'h1, e);
        rx_send(8'h01, 3'b000);
        rx_send(8'h02, 3'b000);
        apb_xfer(1'b1, 5'h04, 32'h23, 1'b1, 8'h03, 3'b000, r, e);
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h0000000A) begin errors++; $display("FAIL rx_flush_status: got %h expected 0000000a", r); end
        apb_rd(5'h04, r, e);
        checks++;
        if (r !== 32'h3 || parity_type !== 2'b11 || baud_rate !== 2'b00) begin
            errors++; $display("FAIL ctrl_flush_read: got %h parity=%b baud=%b expected 3 11 00", r, parity_type, baud_rate);
        end
    endtask

    task automatic test_reset_midchar();
        logic [31:0] r;
        logic e, seen;
        int base;
        do_reset();
        apb_wr(5'h00, 32'h3, e);
        apb_wr(5'h04, 32'hF, e);
        apb_wr(5'h10, 32'h7, e);
        apb_wr(5'h0C, 32'h41, e);
        apb_wr(5'h0C, 32'h42, e);
        apb_wr(5'h0C, 32'h43, e);
        apb_wr(5'h0C, 32'h44, e);
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h00000308 || irq !== 1'b1) begin
            errors++; $display("FAIL midchar_pre: status=%h irq=%b expected 00000308 1", r, irq);
        end
        #3 PRESETn = 1'b0;
        #1;
        checks++;
        if ({tx_start, tx_data, rx_enable, tx_enable, parity_type, baud_rate, irq} !== 16'h0) begin
            errors++; $display("FAIL midchar_async: tx_start=%b tx_data=%h en=%b%b ctrl=%b%b irq=%b expected all 0",
                               tx_start, tx_data, tx_enable, rx_enable, baud_rate, parity_type, irq);
        end
        @(posedge PCLK); #1 PRESETn = 1'b1;
        base = start_cnt;
        apb_rd(5'h08, r, e);
        checks++;
        if (r !== 32'h0000000A) begin errors++; $display("FAIL midchar_status: got %h expected 0000000a", r); end
        apb_rd(5'h10, r, e);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL midchar_irq_en: got %h expected 0", r); end
        wait_start(seen);
        checks++;
        if (seen || start_cnt !== base) begin errors++; $display("FAIL midchar_no_start: seen=%b expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_pslverr();
        test_tx_sequence();
        test_tx_full();
        test_rx_overrun();
        test_rx_pop_push();
        test_rx_err();
        test_flush();
        test_reset_midchar();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
